lfsr_word_gen: RTL and testbench
================================

LFSR_WORD_GEN -- requirements
Module: lfsr_word_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning shift register width (2..64).
REQ-002 The block SHALL have parameter INIT_VALUE, default 16'hACE1, meaning the reset value and the lockup-recovery value (non-zero).
REQ-003 The block SHALL have parameter FEEDBACK, default 16'h002D, meaning the tap mask.
REQ-004 The block SHALL have parameter MODE, default 0, meaning 0 = Fibonacci, 1 = Galois.
REQ-005 The block SHALL have parameter WORD_BITS, default 8, meaning output word width (1..WIDTH).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port random, input, 1 bit: an external entropy bit XORed into the feedback on each step.
REQ-009 The block SHALL have port enable, input, 1 bit: permits stepping.
REQ-010 The block SHALL have port seed_valid, input, 1 bit: a single-cycle seed load strobe.
REQ-011 The block SHALL have port seed, input, WIDTH bits: the seed value.
REQ-012 The block SHALL have port word_ready, input, 1 bit: consumer accept.
REQ-013 The block SHALL have port word_valid, output, 1 bit: a word is available.
REQ-014 The block SHALL have port word, output, WORD_BITS bits: the collected output bits.
REQ-015 The block SHALL have port shiftreg, output, WIDTH bits: the current LFSR state.
REQ-016 The block SHALL have port lockup_count, output, 8 bits: a saturating count of all-zero recoveries.

Function
REQ-017 A step SHALL occur in a cycle when enable=1, seed_valid=0 and the collector is not stalled (REQ-024).
REQ-018 In MODE 0, a step SHALL compute fb = random ^ parity(shiftreg & FEEDBACK) and set shiftreg <= {fb, shiftreg[WIDTH-1:1]}.
REQ-019 In MODE 1, a step SHALL compute o = shiftreg[0] ^ random and set shiftreg <= (shiftreg >> 1) ^ (o ? FEEDBACK : 0).
REQ-020 The output bit of a step SHALL be shiftreg[0] as it was before the step.
REQ-021 If the computed next state is all-zero, shiftreg SHALL instead load INIT_VALUE and lockup_count SHALL increment, saturating at 255.
REQ-022 The collector SHALL have two states: FILL, which accepts bits, and HOLD, which has a word pending.
REQ-023 In FILL, each step SHALL write its output bit at index bit_cnt of the word accumulator, so the first bit lands in the LSB; bit_cnt counts 0..WORD_BITS-1.
REQ-024 The step that supplies bit WORD_BITS-1 SHALL set word_valid=1 on the next cycle, clear bit_cnt to 0 and enter HOLD; the state is HOLD with word_ready=0 is the stall condition, in which shiftreg, word and word_valid hold and random is ignored.
REQ-025 In HOLD with word_ready=1, the word SHALL be consumed and the block SHALL return to FILL in the same cycle; if enable=1, a step occurs in that cycle and collects bit 0 of the next word, giving zero bubble.
REQ-026 With WORD_BITS=1 and word_ready tied to 1, the block SHALL produce one word per cycle.
REQ-027 word SHALL remain stable while word_valid=1 and SHALL change only on the cycle after acceptance or seed load.
REQ-028 When seed_valid=1, shiftreg SHALL load seed, or INIT_VALUE with a lockup_count increment if seed is all-zero; bit_cnt, the accumulator and word_valid SHALL clear, the state SHALL go to FILL, and no step SHALL occur in that cycle.
REQ-029 seed_valid SHALL take priority over enable, word_ready and lockup recovery.
REQ-030 With enable=0 and no seed load, all state SHALL hold, except that a HOLD→FILL acceptance still completes.

Reset
REQ-031 While rst_n=0, the block SHALL set shiftreg=INIT_VALUE, word=0, word_valid=0, bit_cnt=0, state=FILL and lockup_count=0, asynchronously.
REQ-032 Deassertion of rst_n mid-word SHALL discard any partial word, and the first step after release SHALL occur on the first rising edge with enable=1.

Verification
REQ-033 The bench SHALL cover this case: reset, then MODE 0 with defaults, enable=1, random=0, for one step -> shiftreg 0xACE1→0x5670, with output bit 1.
REQ-034 The bench SHALL cover this case: MODE 0 with defaults, enable=1, random=1, for one step from reset -> shiftreg=0xD670.
REQ-035 The bench SHALL cover this case: MODE 1 with FEEDBACK=16'hB400, one step from reset, random=0 -> shiftreg=0xE270.
REQ-036 The bench SHALL cover this case: MODE 0, WORD_BITS=8, random=0, word_ready=1 -> the first word is 0xE1, the second word is 0xAC, and word_valid is high on cycles 9 and 17 after reset release.
REQ-037 The bench SHALL cover this case: word_ready=0 for 5 cycles while in HOLD -> word, word_valid and shiftreg stay constant, and the word is accepted in the cycle word_ready rises.
REQ-038 The bench SHALL cover this case: seed_valid=1 with seed=0 while in HOLD -> shiftreg=0xACE1, word_valid=0, lockup_count=1; 256 such loads -> lockup_count=255.

Source files
------------

// File: rtl/lfsr_word_gen.sv
// lfsr_word_gen
//   LFSR (Fibonacci or Galois) whose per-step output bit (the LSB before the
//   step) is collected LSB-first into WORD_BITS-wide words, handed off with a
//   valid/ready pair. A pending unaccepted word stalls the register.
//   All-zero next states are replaced by INIT_VALUE and counted.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   random       : entropy bit XORed into the feedback on each step
//   enable       : permits stepping
//   seed_valid   : single-cycle seed load strobe (highest priority)
//   seed         : seed value
//   word_ready   : consumer accept
//   word_valid   : a word is available on word
//   word         : collected output bits
//   shiftreg     : current LFSR state
//   lockup_count : saturating count of all-zero recoveries
module lfsr_word_gen #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] INIT_VALUE = 16'hACE1,
  parameter logic [WIDTH-1:0] FEEDBACK   = 16'h002D,
  parameter int unsigned      MODE       = 0,
  parameter int unsigned      WORD_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 random,
  input  logic                 enable,
  input  logic                 seed_valid,
  input  logic [WIDTH-1:0]     seed,
  input  logic                 word_ready,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word,
  output logic [WIDTH-1:0]     shiftreg,
  output logic [7:0]           lockup_count
);

  localparam int unsigned CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  typedef enum logic {FILL, HOLD} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shiftreg_q, shiftreg_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic                 word_valid_q, word_valid_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]           lockup_count_q, lockup_count_d;

  logic [WIDTH-1:0]     next_sr;
  logic                 stall, accept, step, lockup_inc;

  always_comb begin
    state_d        = state_q;
    shiftreg_d     = shiftreg_q;
    word_d         = word_q;
    word_valid_d   = word_valid_q;
    bit_cnt_d      = bit_cnt_q;
    lockup_count_d = lockup_count_q;
    lockup_inc     = 1'b0;

    stall  = (state_q == HOLD) && !word_ready;
    accept = (state_q == HOLD) && word_ready;
    step   = enable && !seed_valid && !stall;

    if (MODE == 0) begin
      next_sr = {random ^ (^(shiftreg_q & FEEDBACK)), shiftreg_q[WIDTH-1:1]};
    end else begin
      next_sr = (shiftreg_q >> 1) ^ ((shiftreg_q[0] ^ random) ? FEEDBACK : '0);
    end

    if (seed_valid) begin
      if (seed == '0) begin
        shiftreg_d = INIT_VALUE;
        lockup_inc = 1'b1;
      end else begin
        shiftreg_d = seed;
      end
      word_d       = '0;
      word_valid_d = 1'b0;
      bit_cnt_d    = '0;
      state_d      = FILL;
    end else begin
      // Acceptance starts a fresh word; a step in the same cycle then drops
      // bit 0 of the next word into it, so there is no bubble.
      if (accept) begin
        state_d      = FILL;
        word_valid_d = 1'b0;
        word_d       = '0;
      end
      if (step) begin
        if (next_sr == '0) begin
          shiftreg_d = INIT_VALUE;
          lockup_inc = 1'b1;
        end else begin
          shiftreg_d = next_sr;
        end
        for (int unsigned i = 0; i < WORD_BITS; i++) begin
          if (CNT_W'(i) == bit_cnt_q) word_d[i] = shiftreg_q[0];
        end
        if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
          bit_cnt_d    = '0;
          state_d      = HOLD;
          word_valid_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end

    if (lockup_inc && (lockup_count_q != 8'hFF)) begin
      lockup_count_d = lockup_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FILL;
      shiftreg_q     <= INIT_VALUE;
      word_q         <= '0;
      word_valid_q   <= 1'b0;
      bit_cnt_q      <= '0;
      lockup_count_q <= '0;
    end else begin
      state_q        <= state_d;
      shiftreg_q     <= shiftreg_d;
      word_q         <= word_d;
      word_valid_q   <= word_valid_d;
      bit_cnt_q      <= bit_cnt_d;
      lockup_count_q <= lockup_count_d;
    end
  end

  assign shiftreg     = shiftreg_q;
  assign word         = word_q;
  assign word_valid   = word_valid_q;
  assign lockup_count = lockup_count_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Testbench for lfsr_word_gen: three instances (Fibonacci/8-bit words,
// Galois 0xB400/5-bit words, Fibonacci/1-bit words) driven by shared
// stimulus and compared every cycle against a behavioural model, plus
// directed checks with hand-computed constants.
module tb_lfsr_word_gen;

  logic        clk;
  logic        rst_n;
  logic        random;
  logic        enable;
  logic        seed_valid;
  logic [15:0] seed;
  logic        word_ready;

  logic        a_valid, b_valid, c_valid;
  logic [7:0]  a_word;
  logic [4:0]  b_word;
  logic [0:0]  c_word;
  logic [15:0] a_sr, b_sr, c_sr;
  logic [7:0]  a_lc, b_lc, c_lc;

  int n_tests = 0;
  int n_fail  = 0;

  lfsr_word_gen #(.WIDTH(16), .INIT_VALUE(16'hACE1), .FEEDBACK(16'h002D),
                  .MODE(0), .WORD_BITS(8)) u_a (
    .clk(clk), .rst_n(rst_n), .random(random), .enable(enable),
    .seed_valid(seed_valid), .seed(seed), .word_ready(word_ready),
    .word_valid(a_valid), .word(a_word), .shiftreg(a_sr), .lockup_count(a_lc));

  lfsr_word_gen #(.WIDTH(16), .INIT_VALUE(16'hACE1), .FEEDBACK(16'hB400),
                  .MODE(1), .WORD_BITS(5)) u_b (
    .clk(clk), .rst_n(rst_n), .random(random), .enable(enable),
    .seed_valid(seed_valid), .seed(seed), .word_ready(word_ready),
    .word_valid(b_valid), .word(b_word), .shiftreg(b_sr), .lockup_count(b_lc));

  lfsr_word_gen #(.WIDTH(16), .INIT_VALUE(16'hACE1), .FEEDBACK(16'h002D),
                  .MODE(0), .WORD_BITS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .random(random), .enable(enable),
    .seed_valid(seed_valid), .seed(seed), .word_ready(word_ready),
    .word_valid(c_valid), .word(c_word), .shiftreg(c_sr), .lockup_count(c_lc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [15:0] sr;
    logic [7:0]  acc;
    logic [7:0]  cnt;
    logic        hold;
    logic [7:0]  lc;
  } mdl_t;

  int          mode_of[3] = '{0, 1, 0};
  logic [15:0] fb_of[3]   = '{16'h002D, 16'hB400, 16'h002D};
  int          wb_of[3]   = '{8, 5, 1};
  string       nm[3]      = '{"A", "B", "C"};

  mdl_t mdl[3];
  mdl_t nxt[3];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.sr = 16'hACE1; r.acc = 8'd0; r.cnt = 8'd0; r.hold = 1'b0; r.lc = 8'd0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int idx, bit en, bit rnd,
                                    bit sv, logic [15:0] sd, bit rdy);
    mdl_t r = m;
    logic [15:0] n;
    bit ob, fbit;
    if (sv) begin
      r.sr = (sd == 16'd0) ? 16'hACE1 : sd;
      if (sd == 16'd0 && r.lc != 8'd255) r.lc = r.lc + 8'd1;
      r.acc = 8'd0; r.cnt = 8'd0; r.hold = 1'b0;
      return r;
    end
    if (r.hold && !rdy) return r;
    if (r.hold) begin
      r.hold = 1'b0;
      r.acc  = 8'd0;
    end
    if (!en) return r;
    ob = r.sr[0];
    if (mode_of[idx] == 0) begin
      fbit = rnd ^ ($countones(r.sr & fb_of[idx]) % 2 == 1);
      n = (r.sr >> 1) | (fbit ? 16'h8000 : 16'h0000);
    end else begin
      n = (r.sr >> 1) ^ ((ob ^ rnd) ? fb_of[idx] : 16'h0000);
    end
    if (n == 16'd0) begin
      n = 16'hACE1;
      if (r.lc != 8'd255) r.lc = r.lc + 8'd1;
    end
    r.sr  = n;
    r.acc = r.acc | (8'(ob) << r.cnt);
    r.cnt = r.cnt + 8'd1;
    if (r.cnt == 8'(wb_of[idx])) begin
      r.cnt  = 8'd0;
      r.hold = 1'b1;
    end
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_inst(input int i);
    logic [15:0] s;
    logic        v;
    logic [7:0]  w, l;
    case (i)
      0:       begin s = a_sr; v = a_valid; w = a_word;     l = a_lc; end
      1:       begin s = b_sr; v = b_valid; w = 8'(b_word); l = b_lc; end
      default: begin s = c_sr; v = c_valid; w = 8'(c_word); l = c_lc; end
    endcase
    check_eq({nm[i], ".shiftreg"}, 64'(s), 64'(mdl[i].sr));
    check_eq({nm[i], ".word_valid"}, 64'(v), 64'(mdl[i].hold));
    check_eq({nm[i], ".lockup_count"}, 64'(l), 64'(mdl[i].lc));
    if (mdl[i].hold) check_eq({nm[i], ".word"}, 64'(w), 64'(mdl[i].acc));
  endtask

  // Advance one clock with the currently driven inputs; compare #1 after edge.
  task automatic tick();
    for (int i = 0; i < 3; i++)
      nxt[i] = mdl_step(mdl[i], i, enable, random, seed_valid, seed, word_ready);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) mdl[i] = nxt[i];
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  // Asynchronous reset pulse placed mid-cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst.A.shiftreg", 64'(a_sr), 64'h ACE1);
    check_eq("rst.A.word", 64'(a_word), 64'h0);
    check_eq("rst.A.word_valid", 64'(a_valid), 64'h0);
    check_eq("rst.A.lockup_count", 64'(a_lc), 64'h0);
    check_eq("rst.C.word_valid", 64'(c_valid), 64'h0);
    for (int i = 0; i < 3; i++) mdl[i] = mdl_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] hold_sr;
  logic [7:0]  hold_word;

  initial begin
    rst_n = 1'b0; random = 1'b0; enable = 1'b0; seed_valid = 1'b0;
    seed = 16'd0; word_ready = 1'b0;
    for (int i = 0; i < 3; i++) mdl[i] = mdl_reset();
    @(posedge clk);
    #1;

    // One Fibonacci step with random=0 and Galois step with 0xB400.
    do_reset();
    enable = 1'b1; random = 1'b0; word_ready = 1'b1;
    tick();
    check_eq("fib.step.r0", 64'(a_sr), 64'h5670);
    check_eq("fib.outbit", 64'(c_word), 64'h1);
    check_eq("gal.step.r0", 64'(b_sr), 64'hE270);

    // One Fibonacci step with random=1.
    do_reset();
    random = 1'b1;
    tick();
    check_eq("fib.step.r1", 64'(a_sr), 64'hD670);

    // Word timing with always-ready consumer.
    do_reset();
    random = 1'b0; word_ready = 1'b1; enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check_eq("c.word_per_cycle", 64'(c_valid), 64'h1);
      if (k == 7 || k == 9) check_eq("a.valid_low", 64'(a_valid), 64'h0);
      if (k == 8) begin
        check_eq("a.word1.valid", 64'(a_valid), 64'h1);
        check_eq("a.word1", 64'(a_word), 64'hE1);
      end
      if (k == 16) begin
        check_eq("a.word2.valid", 64'(a_valid), 64'h1);
        check_eq("a.word2", 64'(a_word), 64'hAC);
      end
    end

    // Stall in HOLD for 5 cycles, then accept.
    do_reset();
    word_ready = 1'b0; enable = 1'b1; random = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check_eq("stall.enter", 64'(a_valid), 64'h1);
    hold_sr = a_sr; hold_word = a_word;
    for (int k = 0; k < 5; k++) begin
      random = 1'($urandom);
      tick();
      check_eq("stall.shiftreg", 64'(a_sr), 64'(hold_sr));
      check_eq("stall.word", 64'(a_word), 64'(hold_word));
      check_eq("stall.valid", 64'(a_valid), 64'h1);
    end
    word_ready = 1'b1;
    tick();
    check_eq("accept.valid", 64'(a_valid), 64'h0);
    word_ready = 1'b0;

    // Zero-seed loads while holding a word.
    do_reset();
    word_ready = 1'b0; enable = 1'b1; random = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    seed_valid = 1'b1; seed = 16'd0;
    tick();
    check_eq("seed0.shiftreg", 64'(a_sr), 64'hACE1);
    check_eq("seed0.valid", 64'(a_valid), 64'h0);
    check_eq("seed0.lockup", 64'(a_lc), 64'h1);
    for (int k = 0; k < 255; k++) tick();
    check_eq("seed0.sat", 64'(a_lc), 64'hFF);
    tick();
    check_eq("seed0.sat_hold", 64'(a_lc), 64'hFF);

    // Step into an all-zero state: seed 1 with random=1.
    do_reset();
    seed_valid = 1'b1; seed = 16'h0001; word_ready = 1'b1;
    tick();
    seed_valid = 1'b0; random = 1'b1; enable = 1'b1;
    tick();
    check_eq("lockup.A.shiftreg", 64'(a_sr), 64'hACE1);
    check_eq("lockup.A.count", 64'(a_lc), 64'h1);
    check_eq("lockup.B.shiftreg", 64'(b_sr), 64'hACE1);

    // Randomized traffic, with occasional mid-word resets.
    for (int k = 0; k < 3000; k++) begin
      enable     = ($urandom_range(0, 9) < 8);
      random     = 1'($urandom);
      word_ready = ($urandom_range(0, 3) != 0);
      seed_valid = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       seed = 16'h0000;
        1:       seed = 16'h0001;
        default: seed = 16'($urandom);
      endcase
      tick();
      if (k % 700 == 350) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
